// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared widths and constants for the 7-segment scan controller
package seg7_pkg;

    localparam int BCD_W = 4;
    localparam int SEG_W = 7;

    localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/seg7_scan_ctrl_if.sv
// rtl/seg7_scan_ctrl_if.sv - digit load / display pin bundle for seg7_scan_ctrl
interface seg7_scan_ctrl_if
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS = 4
);

    logic [BCD_W*NUM_DIGITS-1:0] digits_in;
    logic                        load;
    logic [NUM_DIGITS-1:0]       blank_mask;
    logic                        busy;
    logic                        frame_done;
    logic [NUM_DIGITS-1:0]       anode;
    logic [SEG_W-1:0]            segment;

    modport master (
        output digits_in,
        output load,
        output blank_mask,
        input  busy,
        input  frame_done,
        input  anode,
        input  segment
    );

    modport slave (
        input  digits_in,
        input  load,
        input  blank_mask,
        output busy,
        output frame_done,
        output anode,
        output segment
    );

endinterface

// File: rtl/bcd_to_7segment.sv
// rtl/bcd_to_7segment.sv - combinational BCD to active-low (a..g) segment decoder
module bcd_to_7segment
    import seg7_pkg::*;
(
    input  logic [BCD_W-1:0] bcd,
    output logic [SEG_W-1:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (bcd)
            4'd0: seg = 7'b0000001;
            4'd1: seg = 7'b1001111;
            4'd2: seg = 7'b0010010;
            4'd3: seg = 7'b0000110;
            4'd4: seg = 7'b1001100;
            4'd5: seg = 7'b0100100;
            4'd6: seg = 7'b0100000;
            4'd7: seg = 7'b0001111;
            4'd8: seg = 7'b0000000;
            4'd9: seg = 7'b0000100;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// rtl/seg7_scan_ctrl.sv - N-digit common-anode 7-segment scan controller with tear-free buffering
// Optional leading-zero blanking when SEG7_LEADING_ZERO_BLANK_EN is defined.
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int GUARD_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst,
    seg7_scan_ctrl_if.slave bus
);

    localparam int PW = $clog2(REFRESH_DIV);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam int DW = BCD_W * NUM_DIGITS;

    logic [PW-1:0]         presc_q, presc_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [DW-1:0]         shadow_q, shadow_d;
    logic [DW-1:0]         active_q, active_d;
    logic                  busy_q, busy_d;
    logic                  frame_done_q, frame_done_d;
    logic [NUM_DIGITS-1:0] anode_q, anode_d;
    logic [SEG_W-1:0]      segment_q, segment_d;

    logic             slot_end;
    logic             frame_wrap;
    logic             in_guard;
    logic             lz_blank;
    logic [BCD_W-1:0] cur_bcd;
    logic [SEG_W-1:0] cur_seg;

    bcd_to_7segment u_dec (
        .bcd (cur_bcd),
        .seg (cur_seg)
    );

    always_comb begin
        slot_end   = (presc_q == PW'(REFRESH_DIV - 1));
        frame_wrap = slot_end && (idx_q == IW'(NUM_DIGITS - 1));
        in_guard   = (int'(presc_q) < GUARD_CYCLES);
        cur_bcd    = active_q[idx_q*BCD_W +: BCD_W];
    end

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    // Dark when this digit and every more-significant digit are zero; digit 0 always shows.
    always_comb begin
        lz_blank = (idx_q != '0);
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if ((k >= int'(idx_q)) && (active_q[k*BCD_W +: BCD_W] != '0)) begin
                lz_blank = 1'b0;
            end
        end
    end
`else
    always_comb begin
        lz_blank = 1'b0;
    end
`endif

    always_comb begin
        presc_d      = slot_end ? '0 : presc_q + 1'b1;
        idx_d        = idx_q;
        shadow_d     = shadow_q;
        active_d     = active_q;
        busy_d       = busy_q;
        frame_done_d = frame_wrap;

        if (slot_end) begin
            idx_d = (idx_q == IW'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
        end

        // Commit takes the pre-load shadow, so a load on the wrap cycle waits a frame.
        if (frame_wrap) begin
            active_d = shadow_q;
            busy_d   = 1'b0;
        end
        if (bus.load) begin
            shadow_d = bus.digits_in;
            busy_d   = 1'b1;
        end

        segment_d = cur_seg;
        if (in_guard || bus.blank_mask[idx_q] || lz_blank) begin
            anode_d = '1;
        end else begin
            anode_d = ~(NUM_DIGITS'(1) << idx_q);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q      <= '0;
            idx_q        <= '0;
            shadow_q     <= '0;
            active_q     <= '0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            anode_q      <= '1;
            segment_q    <= SEG_BLANK;
        end else begin
            presc_q      <= presc_d;
            idx_q        <= idx_d;
            shadow_q     <= shadow_d;
            active_q     <= active_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            anode_q      <= anode_d;
            segment_q    <= segment_d;
        end
    end

    assign bus.busy       = busy_q;
    assign bus.frame_done = frame_done_q;
    assign bus.anode      = anode_q;
    assign bus.segment    = segment_q;

endmodule

// File: doc/seg7_scan_ctrl.md
Name: seg7_scan_ctrl

Overview:
- Time-multiplexed scan controller for an N-digit common-anode 7-segment display.
- Holds a BCD digit buffer and cycles through the digits at a programmable refresh rate.
- Routes each digit through one shared BCD-to-7-segment decoder and drives active-low segment and anode lines.
- Sits between the numeric datapath (counters, timers) and the board display pins.

Parameters:
- NUM_DIGITS, 4: digits scanned; legal range 2..8.
- REFRESH_DIV, 50000: clk cycles per digit slot; must be >= GUARD_CYCLES+2.
- GUARD_CYCLES, 2: clk cycles at the start of each slot with all anodes off (anti-ghosting).

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- digits_in  input  4*NUM_DIGITS  BCD digits; digit 0 is bits [3:0] and is the rightmost digit
- load  input  1  capture digits_in into the shadow buffer this cycle
- blank_mask  input  NUM_DIGITS  bit i=1 forces digit i dark
- busy  output  1  shadow buffer holds data not yet committed to the active buffer
- frame_done  output  1  one-cycle pulse when the last digit slot ends
- anode  output  NUM_DIGITS  active-low digit enables
- segment  output  7  active-low (a,b,c,d,e,f,g); a segment glows when its bit is 0

Behaviour:
- Reset (asynchronous, active-high) forces:
  - anode = all 1s, segment = 7'b1111111
  - busy = 0, frame_done = 0
  - prescaler = 0, digit index = 0
  - shadow and active buffers = all zeros
- Prescaler:
  - Counts 0..REFRESH_DIV-1 and wraps to 0.
  - slot_end is asserted when the count equals REFRESH_DIV-1.
- Digit index:
  - On slot_end, idx increments; NUM_DIGITS-1 wraps to 0.
  - frame_done is registered high for exactly the cycle after slot_end with idx==NUM_DIGITS-1.
- Buffering (tear-free update):
  - load=1: shadow <= digits_in, busy <= 1.
  - At a frame wrap (slot_end with idx==NUM_DIGITS-1): active <= shadow, busy <= 0.
  - load and frame wrap in the same cycle: active takes the old shadow, shadow takes the new digits_in, busy stays 1.
  - Repeated loads before a wrap: the last one wins.
- Output stage:
  - Registered. anode and segment change 1 clk after the prescaler/idx state that selects them.
  - Guard window, prescaler < GUARD_CYCLES: anode = all 1s; segment still presents the decoded digit.
  - Otherwise: anode = ~(1<<idx) unless blank_mask[idx]=1, which gives all 1s.
  - blank_mask is sampled live, with no buffering.
- Decoding:
  - segment = decode(active[idx]).
  - Values 10..15 decode to 7'b1111111 (dark), and the anode is still driven.
- Reset mid-scan: outputs go dark immediately and the scan restarts at digit 0 after release.

Optional Feature:
- Macro: SEG7_LEADING_ZERO_BLANK_EN.
- Defined: digit i is also blanked (anode all 1s) when active digits i..NUM_DIGITS-1 are all zero and i != 0. A value of 0 shows only digit 0. The blank decision uses the active buffer.
- Undefined: every digit is shown unless blank_mask says otherwise.

Decomposition:
- Shared package seg7_pkg holds:
  - SEG_BLANK = 7'b1111111
  - digit/segment width constants (BCD_W=4, SEG_W=7)
- One sub-module: the existing bcd_to_7segment decoder, instantiated once as the shared decoder. The mux selects the BCD input and the controller registers the decoder output.

Test Plan:
All scenarios use NUM_DIGITS=4, REFRESH_DIV=4, GUARD_CYCLES=1.
1. Reset, then release with no load -> anode cycles 1110, 1101, 1011, 0111. Each slot has 1 guard clk at 1111, then 3 clk active. segment=7'b0000001 throughout the active clks. frame_done pulses every 16 clk.
2. load with digits_in=16'h1234 mid-frame -> busy=1 until the frame wrap. From the next frame: digit0 shows 7'b1001100 (4), digit3 shows 7'b1001111 (1). busy=0.
3. load 16'h1111, then 16'h5678 in the same frame -> only 5678 is ever displayed. load on the wrap cycle itself -> the old shadow commits and busy stays 1 for another frame.
4. digits_in=16'h00FA with blank_mask=4'b0100 -> digit0 (A) gives segment 1111111 with its anode low. Digit2 anode is never low.
5. Assert rst during digit 2's active slot -> anode=1111 and segment=1111111 asynchronously. After release, the first active anode is 1110 at clk 2.
6. With SEG7_LEADING_ZERO_BLANK_EN defined and digits 16'h0050 -> digits 3 and 2 stay dark, digits 1 and 0 show 5 and 0. With 16'h0000, only digit 0 lights.
